// File: rtl/decode_pipe.sv
// decode_pipe: single-register MIPS-32 decode stage.
// Splits an accepted instruction into its fields, classifies it (R/J/I/HALT),
// extends the immediate, and presents the bundle with a valid/ready handshake.
// A small FSM inserts a one-cycle bubble after a load whose destination the
// next instruction reads, and parks the stage once a HALT has been accepted.
module decode_pipe #(
    parameter int IMM_W     = 32,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       sa,
    output logic [5:0]       funct,
    output logic [25:0]      instr_address,
    output logic [IMM_W-1:0] imm,
    output logic [1:0]       InstructionType,
    output logic             illegal,
    output logic             halted
);

    // Supported primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef enum logic [1:0] {
        IT_R    = 2'd0,
        IT_J    = 2'd1,
        IT_HALT = 2'd2,
        IT_I    = 2'd3
    } itype_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Everything the execute stage sees, captured together on accept
    typedef struct packed {
        logic [5:0]       opcode;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       sa;
        logic [5:0]       funct;
        logic [25:0]      instr_address;
        logic [IMM_W-1:0] imm;
        itype_e           itype;
        logic             illegal;
    } bundle_t;

    // Incoming instruction fields
    logic [5:0]  w_in_op;
    logic [4:0]  w_in_rs;
    logic [4:0]  w_in_rt;
    logic        w_is_itype;
    bundle_t     w_dec;

    // Hazard / handshake
    logic        w_lw_held;
    logic        w_reads_rs;
    logic        w_reads_rt;
    logic        w_hazard;
    logic        w_accept;
    logic        w_out_fire;

    // State
    bundle_t     r_bundle;
    logic        r_valid;
    state_e      r_state;
    logic        r_halted;

    assign w_in_op    = instruction[31:26];
    assign w_in_rs    = instruction[25:21];
    assign w_in_rt    = instruction[20:16];
    assign w_is_itype = w_in_op inside {OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE};

    // Combinational decode of the offered instruction into a bundle
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch behind.
        w_dec = '0;
        if (w_in_op == OP_RTYPE) begin
            w_dec.opcode = w_in_op;
            w_dec.itype  = IT_R;
            w_dec.rs     = w_in_rs;
            w_dec.rt     = w_in_rt;
            w_dec.rd     = instruction[15:11];
            w_dec.sa     = instruction[10:6];
            w_dec.funct  = instruction[5:0];
        end else if (w_in_op == OP_J) begin
            w_dec.opcode        = w_in_op;
            w_dec.itype         = IT_J;
            w_dec.instr_address = instruction[25:0];
        end else if (w_in_op == OP_HALT) begin
            w_dec.opcode = w_in_op;
            w_dec.itype  = IT_HALT;
        end else if (w_is_itype) begin
            w_dec.opcode = w_in_op;
            w_dec.itype  = IT_I;
            w_dec.rs     = w_in_rs;
            w_dec.rt     = w_in_rt;
            // ANDI is a logical op, so its immediate is zero-extended
            if (w_in_op == OP_ANDI) begin
                w_dec.imm = IMM_W'(instruction[15:0]);
            end else begin
                w_dec.imm = IMM_W'($signed(instruction[15:0]));
            end
        end else begin
            // Unsupported opcode: flag it and leave every field zero
            w_dec.itype   = IT_R;
            w_dec.illegal = 1'b1;
        end
    end

    // Load-use detection against the load sitting in the output register.
    // Deliberately independent of in_valid so in_ready never depends on it.
    assign w_lw_held  = r_valid && (r_bundle.opcode == OP_LW) && (r_bundle.rt != 5'd0);
    assign w_reads_rs = (w_in_op == OP_RTYPE) || w_is_itype;
    assign w_reads_rt = (w_in_op == OP_RTYPE) || (w_in_op == OP_SW) ||
                        (w_in_op == OP_BEQ)   || (w_in_op == OP_BNE);
    assign w_hazard   = HAZARD_EN && w_lw_held &&
                        ((w_reads_rs && (w_in_rs == r_bundle.rt)) ||
                         (w_reads_rt && (w_in_rt == r_bundle.rt)));

    assign in_ready   = !flush && (r_state == ST_RUN) && (!r_valid || out_ready) && !w_hazard;
    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = r_valid && out_ready;

    // Output register: load on accept, drain on consume, cleared by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the bundle is a handful of flops, not a memory, so it is reset to zero outright.
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (flush) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_bundle <= w_dec;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

    // Stage control FSM with registered halted flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // A flush overrides both the halt capture and the bubble
                    if (!flush) begin
                        if (w_accept && (w_dec.itype == IT_HALT)) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end else if (w_out_fire && w_hazard) begin
                            r_state <= ST_BUBBLE;
                        end
                    end
                end
                ST_BUBBLE: begin
                    r_state <= ST_RUN;
                end
                ST_HALTED: begin
                    // Only reset leaves this state
                    r_state  <= ST_HALTED;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid       = r_valid;
    assign opcode          = r_bundle.opcode;
    assign rs              = r_bundle.rs;
    assign rt              = r_bundle.rt;
    assign rd              = r_bundle.rd;
    assign sa              = r_bundle.sa;
    assign funct           = r_bundle.funct;
    assign instr_address   = r_bundle.instr_address;
    assign imm             = r_bundle.imm;
    assign InstructionType = r_bundle.itype;
    assign illegal         = r_bundle.illegal;
    assign halted          = r_halted;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed plus randomized checks of decode_pipe against a
// cycle-level reference model built from the decode and handshake rules.
module tb_decode_pipe;

    localparam int IMM_W = 32;

    localparam int M_RUN    = 0;
    localparam int M_BUBBLE = 1;
    localparam int M_HALTED = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       sa;
    logic [5:0]       funct;
    logic [25:0]      instr_address;
    logic [IMM_W-1:0] imm;
    logic [1:0]       InstructionType;
    logic             illegal;
    logic             halted;

    always #5 clk = ~clk;

    decode_pipe #(.IMM_W(IMM_W), .HAZARD_EN(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instruction    (instruction),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .sa             (sa),
        .funct          (funct),
        .instr_address  (instr_address),
        .imm            (imm),
        .InstructionType(InstructionType),
        .illegal        (illegal),
        .halted         (halted)
    );

    typedef struct packed {
        logic [5:0]       opcode;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       sa;
        logic [5:0]       funct;
        logic [25:0]      addr;
        logic [IMM_W-1:0] imm;
        logic [1:0]       itype;
        logic             illegal;
    } bundle_t;

    int      checks   = 0;
    int      failures = 0;

    // Reference model state
    bundle_t m_b;
    logic    m_valid;
    int      m_mode;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_i_op(input int op);
        return (op == 8) || (op == 12) || (op == 35) || (op == 43) || (op == 4) || (op == 5);
    endfunction

    // Field extraction written straight from the instruction-format rules
    function automatic bundle_t ref_decode(input logic [31:0] w);
        bundle_t b;
        int      op;
        longint  v;
        b  = '0;
        op = int'(w[31:26]);
        if (op == 0) begin
            b.opcode = 6'd0;  b.itype = 2'd0;
            b.rs = w[25:21];  b.rt = w[20:16]; b.rd = w[15:11];
            b.sa = w[10:6];   b.funct = w[5:0];
        end else if (op == 2) begin
            b.opcode = 6'd2;  b.itype = 2'd1; b.addr = w[25:0];
        end else if (op == 63) begin
            b.opcode = 6'd63; b.itype = 2'd2;
        end else if (is_i_op(op)) begin
            b.opcode = op[5:0]; b.itype = 2'd3;
            b.rs = w[25:21];    b.rt = w[20:16];
            v = longint'(w[15:0]);
            if (op != 12 && v >= 32768) v = v - 65536;
            b.imm = v[IMM_W-1:0];
        end else begin
            b.illegal = 1'b1;
        end
        return b;
    endfunction

    function automatic bit ref_hazard(input logic [31:0] w);
        int op;
        bit rd_rs;
        bit rd_rt;
        op    = int'(w[31:26]);
        rd_rs = (op == 0) || is_i_op(op);
        rd_rt = (op == 0) || (op == 43) || (op == 4) || (op == 5);
        return m_valid && (m_b.opcode == 6'd35) && (m_b.rt != 5'd0) &&
               ((rd_rs && w[25:21] == m_b.rt) || (rd_rt && w[20:16] == m_b.rt));
    endfunction

    task automatic model_reset();
        m_b     = '0;
        m_valid = 1'b0;
        m_mode  = M_RUN;
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, m_valid);
        check("halted", halted, m_mode == M_HALTED);
        if (m_valid) begin
            check("opcode", opcode, m_b.opcode);
            check("rs", rs, m_b.rs);
            check("rt", rt, m_b.rt);
            check("rd", rd, m_b.rd);
            check("sa", sa, m_b.sa);
            check("funct", funct, m_b.funct);
            check("instr_address", instr_address, m_b.addr);
            check("imm", imm, m_b.imm);
            check("itype", InstructionType, m_b.itype);
            check("illegal", illegal, m_b.illegal);
        end
    endtask

    // One clock: drive at negedge, check in_ready, advance model, check after posedge
    task automatic step(input logic v, input logic [31:0] ins, input logic f, input logic ordy);
        bit hz;
        bit exp_rdy;
        bit acc;
        bit fire;
        @(negedge clk);
        in_valid    = v;
        instruction = ins;
        flush       = f;
        out_ready   = ordy;
        #1;
        hz      = ref_hazard(ins);
        exp_rdy = !f && (m_mode == M_RUN) && (!m_valid || ordy) && !hz;
        check("in_ready", in_ready, exp_rdy);
        acc  = v && exp_rdy;
        fire = m_valid && ordy;
        if (f) begin
            m_valid = 1'b0;
            if (m_mode == M_BUBBLE) m_mode = M_RUN;
        end else if (m_mode == M_BUBBLE) begin
            m_mode = M_RUN;
        end else if (acc) begin
            m_valid = 1'b1;
            m_b     = ref_decode(ins);
            if (m_b.itype == 2'd2) m_mode = M_HALTED;
        end else if (fire) begin
            m_valid = 1'b0;
            if (hz && m_mode == M_RUN) m_mode = M_BUBBLE;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  op;
        case ($urandom_range(0, 9))
            0, 1:    op = 6'd0;
            2:       op = 6'd2;
            3:       op = 6'd8;
            4:       op = 6'd12;
            5, 6:    op = 6'd35;
            7:       op = 6'd43;
            8:       op = ($urandom_range(0, 1) == 0) ? 6'd4 : 6'd5;
            default: op = 6'($urandom_range(0, 62));
        endcase
        w          = $urandom;
        w[31:26]   = op;
        // Small register numbers make load-use collisions frequent
        w[25:21]   = 5'($urandom_range(0, 3));
        w[20:16]   = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = 32'h0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        model_reset();

        // Reset state
        #12;
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.halted", halted, 1'b0);
        check("rst.illegal", illegal, 1'b0);
        check("rst.itype", InstructionType, 2'd0);
        check("rst.imm", imm, '0);
        check("rst.opcode", opcode, 6'd0);
        check("rst.instr_address", instr_address, 26'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI with negative immediate: sign extension
        step(1'b1, 32'h2022FFFF, 1'b0, 1'b1);
        check("addi.itype", InstructionType, 2'd3);
        check("addi.rs", rs, 5'd1);
        check("addi.rt", rt, 5'd2);
        check("addi.imm", imm, 32'hFFFFFFFF);

        // ANDI zero-extends, J carries the target
        step(1'b1, 32'h3022FFFF, 1'b0, 1'b1);
        check("andi.imm", imm, 32'h0000FFFF);
        step(1'b1, 32'h08000010, 1'b0, 1'b1);
        check("j.itype", InstructionType, 2'd1);
        check("j.addr", instr_address, 26'h10);
        check("j.imm", imm, 32'h0);

        // LW r3 followed by ADD reading r3: hold, bubble, then ADD
        step(1'b1, 32'h8C230000, 1'b0, 1'b1);
        step(1'b1, 32'h00652020, 1'b0, 1'b1);
        check("lu.bubble_valid", out_valid, 1'b0);
        step(1'b1, 32'h00652020, 1'b0, 1'b1);
        step(1'b1, 32'h00652020, 1'b0, 1'b1);
        check("lu.add_valid", out_valid, 1'b1);
        check("lu.add_rs", rs, 5'd3);
        check("lu.add_rt", rt, 5'd5);
        check("lu.add_rd", rd, 5'd4);
        check("lu.add_funct", funct, 6'h20);

        // Backpressure: bundle held for three cycles, then drains and refills
        step(1'b1, 32'h2022FFFF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h3022FFFF, 1'b0, 1'b0);
            check("stall.imm", imm, 32'hFFFFFFFF);
        end
        step(1'b1, 32'h3022FFFF, 1'b0, 1'b1);
        check("stall.release_imm", imm, 32'h0000FFFF);

        // Unsupported opcode, then a flush in the accept cycle
        step(1'b1, 32'h7C000000, 1'b0, 1'b1);
        check("ill.flag", illegal, 1'b1);
        check("ill.itype", InstructionType, 2'd0);
        check("ill.opcode", opcode, 6'd0);
        check("ill.rs", rs, 5'd0);
        check("ill.imm", imm, 32'h0);
        step(1'b1, 32'h2022FFFF, 1'b1, 1'b1);
        check("flush.out_valid", out_valid, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 8), rand_instr(), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 7));
        end

        // Drain, then HALT
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'hFC000000, 1'b0, 1'b1);
        check("halt.itype", InstructionType, 2'd2);
        check("halt.opcode", opcode, 6'h3F);
        check("halt.halted", halted, 1'b1);
        step(1'b1, 32'h2022FFFF, 1'b0, 1'b0);
        step(1'b1, 32'h2022FFFF, 1'b1, 1'b1);
        step(1'b1, 32'h2022FFFF, 1'b0, 1'b1);
        check("halt.stays", halted, 1'b1);
        check("halt.in_ready", in_ready, 1'b0);

        // Asynchronous reset pulse returns the stage to RUN
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.halted", halted, 1'b0);
        check("arst.out_valid", out_valid, 1'b0);
        check("arst.itype", InstructionType, 2'd0);
        check("arst.imm", imm, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst.in_ready", in_ready, 1'b1);
        step(1'b1, 32'h08000010, 1'b0, 1'b1);
        check("arst.j_itype", InstructionType, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
